// File: rtl/change_dispenser.sv
// Greedy three-tube coin payout: turns a refund amount into ejector handshakes,
// tracks tube inventories and reports completion, shortfall and jams.
module change_dispenser #(
    parameter int unsigned AMT_W       = 4,
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned D0          = 10,
    parameter int unsigned D1          = 5,
    parameter int unsigned D2          = 1,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refund_valid,
    input  logic [AMT_W-1:0] refund_amt,
    output logic             ready,
    output logic             eject_req,
    output logic [1:0]       eject_sel,
    input  logic             eject_ack,
    output logic             done,
    output logic             shortfall,
    output logic             jam,
    output logic [AMT_W-1:0] fault_amt,
    input  logic             clear_fault,
    input  logic             tube_load,
    input  logic [1:0]       tube_sel,
    input  logic [CNT_W-1:0] tube_val,
    output logic [CNT_W-1:0] tube_cnt0,
    output logic [CNT_W-1:0] tube_cnt1,
    output logic [CNT_W-1:0] tube_cnt2
);

    localparam int unsigned TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    localparam logic [AMT_W-1:0] DEN0 = AMT_W'(D0);
    localparam logic [AMT_W-1:0] DEN1 = AMT_W'(D1);
    localparam logic [AMT_W-1:0] DEN2 = AMT_W'(D2);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        REQ,
        GAP,
        DONE,
        FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [1:0]       sel_q, sel_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             short_q, short_d;
    logic             jam_q, jam_d;
    logic [AMT_W-1:0] famt_q, famt_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic [CNT_W-1:0] cnt2_q, cnt2_d;

    logic             hit0, hit1, hit2;
    logic [AMT_W-1:0] sel_den;
    logic             load_ok;

    // A tube is eligible only if its coin still fits and it is not empty,
    // which is what keeps remaining and the counts from underflowing.
    assign hit0 = (DEN0 <= rem_q) && (cnt0_q != '0);
    assign hit1 = (DEN1 <= rem_q) && (cnt1_q != '0);
    assign hit2 = (DEN2 <= rem_q) && (cnt2_q != '0);

    assign load_ok = (state_q == IDLE) || (state_q == FAULT);

    always_comb begin
        sel_den = '0;
        case (sel_q)
            2'd0:    sel_den = DEN0;
            2'd1:    sel_den = DEN1;
            2'd2:    sel_den = DEN2;
            default: sel_den = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        to_d    = to_q;
        gap_d   = gap_q;
        short_d = short_q;
        jam_d   = jam_q;
        famt_d  = famt_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;

        if (load_ok && tube_load) begin
            case (tube_sel)
                2'd0:    cnt0_d = tube_val;
                2'd1:    cnt1_d = tube_val;
                2'd2:    cnt2_d = tube_val;
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (refund_valid) begin
                    rem_d   = refund_amt;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (rem_q == '0) begin
                    state_d = DONE;
                end else if (hit0 || hit1 || hit2) begin
                    sel_d   = hit0 ? 2'd0 : (hit1 ? 2'd1 : 2'd2);
                    to_d    = '0;
                    state_d = REQ;
                end else begin
                    short_d = 1'b1;
                    famt_d  = rem_q;
                    state_d = FAULT;
                end
            end
            REQ: begin
                if (eject_ack) begin
                    rem_d = rem_q - sel_den;
                    case (sel_q)
                        2'd0:    cnt0_d = cnt0_q - CNT_W'(1);
                        2'd1:    cnt1_d = cnt1_q - CNT_W'(1);
                        2'd2:    cnt2_d = cnt2_q - CNT_W'(1);
                        default: ;
                    endcase
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? SELECT : GAP;
                end else if (to_q == TO_LAST) begin
                    jam_d   = 1'b1;
                    famt_d  = rem_q;
                    state_d = FAULT;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = SELECT;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (clear_fault) begin
                    short_d = 1'b0;
                    jam_d   = 1'b0;
                    famt_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sel_q   <= '0;
            to_q    <= '0;
            gap_q   <= '0;
            short_q <= 1'b0;
            jam_q   <= 1'b0;
            famt_q  <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            to_q    <= to_d;
            gap_q   <= gap_d;
            short_q <= short_d;
            jam_q   <= jam_d;
            famt_q  <= famt_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign eject_req = (state_q == REQ);
    assign done      = (state_q == DONE);
    assign eject_sel = sel_q;
    assign shortfall = short_q;
    assign jam       = jam_q;
    assign fault_amt = famt_q;
    assign tube_cnt0 = cnt0_q;
    assign tube_cnt1 = cnt1_q;
    assign tube_cnt2 = cnt2_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: hand-computed greedy payouts, shortfall,
// jam timeout, zero refund and mid-ejection reset.
module tb_change_dispenser;

    logic       clk;
    logic       reset;
    logic       refund_valid;
    logic [3:0] refund_amt;
    logic       ready;
    logic       eject_req;
    logic [1:0] eject_sel;
    logic       eject_ack;
    logic       done;
    logic       shortfall;
    logic       jam;
    logic [3:0] fault_amt;
    logic       clear_fault;
    logic       tube_load;
    logic [1:0] tube_sel;
    logic [5:0] tube_val;
    logic [5:0] tube_cnt0;
    logic [5:0] tube_cnt1;
    logic [5:0] tube_cnt2;

    change_dispenser #(
        .AMT_W      (4),
        .CNT_W      (6),
        .D0         (10),
        .D1         (5),
        .D2         (1),
        .GAP_CYCLES (2),
        .ACK_TIMEOUT(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .refund_valid(refund_valid),
        .refund_amt  (refund_amt),
        .ready       (ready),
        .eject_req   (eject_req),
        .eject_sel   (eject_sel),
        .eject_ack   (eject_ack),
        .done        (done),
        .shortfall   (shortfall),
        .jam         (jam),
        .fault_amt   (fault_amt),
        .clear_fault (clear_fault),
        .tube_load   (tube_load),
        .tube_sel    (tube_sel),
        .tube_val    (tube_val),
        .tube_cnt0   (tube_cnt0),
        .tube_cnt1   (tube_cnt1),
        .tube_cnt2   (tube_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] sel_log [16];
    int         sel_n;
    int         done_n;
    int         done_cyc;
    int         req_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] sel, input logic [5:0] val);
        tube_load = 1'b1;
        tube_sel  = sel;
        tube_val  = val;
        tick();
        tube_load = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int c0, input int c1, input int c2);
        check({tag, "_cnt0"}, 32'(tube_cnt0), c0);
        check({tag, "_cnt1"}, 32'(tube_cnt1), c1);
        check({tag, "_cnt2"}, 32'(tube_cnt2), c2);
    endtask

    // exp holds the expected tube sequence, element 0 in the lowest two bits.
    task automatic check_seq(input string tag, input int n_exp, input logic [15:0] exp);
        check({tag, "_nsel"}, sel_n, n_exp);
        for (int i = 0; i < n_exp && i < 8; i++)
            check($sformatf("%s_sel%0d", tag, i), 32'(sel_log[i]), 32'(exp[2*i +: 2]));
    endtask

    // Ejector model acks in the second cycle of each request when ack_en is set.
    task automatic pay(input string tag, input logic [3:0] amt, input bit ack_en, input bit inject);
        int cyc;
        int age;
        sel_n    = 0;
        done_n   = 0;
        done_cyc = -1;
        req_cyc  = 0;
        age      = 0;
        refund_amt   = amt;
        refund_valid = 1'b1;
        tick();
        refund_valid = 1'b0;
        refund_amt   = '0;
        for (cyc = 0; cyc < 200; cyc++) begin
            if (done) begin
                if (done_n == 0) done_cyc = cyc;
                done_n++;
            end
            if (shortfall || jam) break;
            if (done_n > 0 && !done) break;
            if (eject_req) begin
                req_cyc++;
                eject_ack = ack_en && (age == 1);
                if (eject_ack) begin
                    if (sel_n < 16) sel_log[sel_n] = eject_sel;
                    sel_n++;
                end
                age++;
            end else begin
                eject_ack = 1'b0;
                age       = 0;
            end
            if (inject && cyc == 3) begin
                refund_valid = 1'b1;
                refund_amt   = 4'd9;
            end else begin
                refund_valid = 1'b0;
                refund_amt   = '0;
            end
            tick();
        end
        eject_ack    = 1'b0;
        refund_valid = 1'b0;
        check({tag, "_bound"}, 32'(cyc < 200), 1);
    endtask

    initial begin
        int w;
        reset        = 1'b1;
        refund_valid = 1'b0;
        refund_amt   = '0;
        eject_ack    = 1'b0;
        clear_fault  = 1'b0;
        tube_load    = 1'b0;
        tube_sel     = '0;
        tube_val     = '0;
        tick();
        tick();
        check("rst_ready", 32'(ready), 1);
        check("rst_req", 32'(eject_req), 0);
        check("rst_done", 32'(done), 0);
        check("rst_short", 32'(shortfall), 0);
        check("rst_jam", 32'(jam), 0);
        check("rst_famt", 32'(fault_amt), 0);
        check("rst_sel", 32'(eject_sel), 0);
        check_counts("rst", 0, 0, 0);
        reset = 1'b0;
        tick();

        // 13 from 5/5/5: one ten then three ones; 4 coins x 5 cycles + SELECT
        load(2'd0, 6'd5);
        load(2'd1, 6'd5);
        load(2'd2, 6'd5);
        pay("t1", 4'd13, 1'b1, 1'b0);
        check_seq("t1", 4, {8'h0, 2'd2, 2'd2, 2'd2, 2'd0});
        check("t1_done_n", done_n, 1);
        check("t1_done_cyc", done_cyc, 21);
        check("t1_ready", 32'(ready), 1);
        check_counts("t1", 4, 5, 2);

        load(2'd3, 6'd7);
        check_counts("sel3", 4, 5, 2);

        // 13 without tens, with a stray request mid-payout that must be dropped
        load(2'd0, 6'd0);
        load(2'd1, 6'd5);
        load(2'd2, 6'd5);
        pay("t2", 4'd13, 1'b1, 1'b1);
        check_seq("t2", 5, {6'h0, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1});
        check("t2_done_n", done_n, 1);
        check_counts("t2", 0, 3, 2);
        tick();
        tick();
        check("t2_idle_req", 32'(eject_req), 0);
        check("t2_idle_ready", 32'(ready), 1);
        check_counts("t2_after", 0, 3, 2);

        // 8 from 0/1/2 runs dry with 1 unpaid
        load(2'd1, 6'd1);
        load(2'd2, 6'd2);
        pay("t3", 4'd8, 1'b1, 1'b0);
        check_seq("t3", 3, {10'h0, 2'd2, 2'd2, 2'd1});
        check("t3_short", 32'(shortfall), 1);
        check("t3_jam", 32'(jam), 0);
        check("t3_famt", 32'(fault_amt), 1);
        check("t3_ready", 32'(ready), 0);
        check("t3_done_n", done_n, 0);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("t3_clr_ready", 32'(ready), 1);
        check("t3_clr_short", 32'(shortfall), 0);
        check("t3_clr_famt", 32'(fault_amt), 0);
        check_counts("t3", 0, 0, 0);

        // ack never arrives: 16 request cycles then jam
        load(2'd1, 6'd2);
        pay("t4", 4'd5, 1'b0, 1'b0);
        check("t4_req_cyc", req_cyc, 16);
        check("t4_jam", 32'(jam), 1);
        check("t4_short", 32'(shortfall), 0);
        check("t4_famt", 32'(fault_amt), 5);
        check("t4_req_off", 32'(eject_req), 0);
        check_counts("t4", 0, 2, 0);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("t4_clr_jam", 32'(jam), 0);
        check("t4_clr_ready", 32'(ready), 1);

        // zero refund completes without touching the ejector
        pay("t5", 4'd0, 1'b1, 1'b0);
        check("t5_req_cyc", req_cyc, 0);
        check("t5_done_cyc", done_cyc, 1);
        check("t5_done_n", done_n, 1);

        // reset during an outstanding request
        load(2'd2, 6'd3);
        refund_amt   = 4'd2;
        refund_valid = 1'b1;
        tick();
        refund_valid = 1'b0;
        for (w = 0; w < 20 && !eject_req; w++) tick();
        check("t6_req_seen", 32'(eject_req), 1);
        check("t6_req_sel", 32'(eject_sel), 2);
        reset = 1'b1;
        tick();
        check("t6_req", 32'(eject_req), 0);
        check("t6_ready", 32'(ready), 1);
        check("t6_done", 32'(done), 0);
        check("t6_short", 32'(shortfall), 0);
        check("t6_jam", 32'(jam), 0);
        check("t6_famt", 32'(fault_amt), 0);
        check("t6_sel", 32'(eject_sel), 0);
        check_counts("t6", 0, 0, 0);
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
